// File: rtl/serial_alu_seq_if.sv
// Host-side request/response bus of the bit-serial ALU sequencer.
// Handshake: the host raises start with op/opa/opb/cin stable. The request
// is taken on the first rising edge where the sequencer is idle (busy low).
// The result and cout are then valid in the single cycle where valid is high,
// and they hold until the next accepted start.
interface serial_alu_seq_if #(
  parameter int WORD = 4
);
  logic            start;
  logic [2:0]      op;
  logic [WORD-1:0] opa;
  logic [WORD-1:0] opb;
  logic            cin;
  logic            busy;
  logic            valid;
  logic [WORD-1:0] result;
  logic            cout;

  modport master (
    output start, op, opa, opb, cin,
    input  busy, valid, result, cout
  );

  modport slave (
    input  start, op, opa, opb, cin,
    output busy, valid, result, cout
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer around an external 1-bit ALU slice. It presents the
// operand bits LSB first and threads the chain bit from one bit to the next.
// It assembles the result word from the slice outputs.
module serial_alu_seq #(
  parameter int WORD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_alu_seq_if.slave  bus,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  output logic [2:0]       alu_s,
  input  logic             alu_out,
  input  logic             alu_cout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough to reach WORD, so the counter never wraps within an operation.
  localparam int CW = $clog2(WORD + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  state_t          state, state_nx;
  logic [WORD-1:0] a_sr, b_sr, res_r;
  logic [2:0]      op_r;
  logic            chain;
  logic            cout_r;
  logic [CW-1:0]   cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. Start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. It latches operands on accept and then shifts one bit per SHIFT cycle.
  // The result enters at the MSB, so after WORD shifts bit i sits at result[i].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_r  <= '0;
      op_r   <= '0;
      chain  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && bus.start) begin
      a_sr  <= bus.opa;
      b_sr  <= bus.opb;
      op_r  <= bus.op;
      chain <= bus.cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res_r <= {alu_out, res_r[WORD-1:1]};
      chain <= alu_cout;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) cout_r <= alu_cout;
    end
  end

  // Slice drive is live only in SHIFT, and it is quiet at zero otherwise.
  always_comb begin
    alu_a = 1'b0;
    alu_b = 1'b0;
    alu_c = 1'b0;
    alu_s = 3'b000;
    if (state == SHIFT) begin
      alu_a = a_sr[0];
      alu_b = b_sr[0];
      alu_c = chain;
      alu_s = op_r;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.valid  = (state == DONE);
  assign bus.result = res_r;
  assign bus.cout   = cout_r;
  assign dbg_state  = state;

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter WORD, default 4, SHALL set the operand and result width in bits (legal values 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request an operation; accepted only in IDLE.
REQ-005 op  input  3  SHALL be the slice operation select, sampled on accept.
REQ-006 opa, opb  input  WORD each  SHALL be operands A and B, sampled on accept.
REQ-007 cin  input  1  SHALL be the chain seed for bit 0, sampled on accept.
REQ-008 alu_a, alu_b, alu_c  output  1 each  SHALL drive the 1-bit ALU slice operand and chain inputs.
REQ-009 alu_s  output  3  SHALL drive the slice operation select.
REQ-010 alu_out, alu_cout  input  1 each  SHALL carry the slice result bit and chain-out bit (combinational from alu_* outputs).
REQ-011 busy  output  1  SHALL be high in SHIFT and DONE.
REQ-012 valid  output  1  SHALL pulse high for exactly one cycle in DONE.
REQ-013 result  output  WORD  SHALL hold the assembled result word.
REQ-014 cout  output  1  SHALL hold the final chain bit.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-016 IDLE with start=1 at an edge SHALL: latch opa/opb into shift registers, latch op, set chain=cin, clear bit counter, and enter SHIFT.
REQ-017 start SHALL be ignored in SHIFT and DONE; latched operands SHALL not change until the next accept.
REQ-018 In SHIFT, alu_a and alu_b SHALL be bit 0 of the A and B shift registers, alu_c SHALL be the chain register, and alu_s SHALL be the latched op.
REQ-019 Each SHIFT edge SHALL: shift A and B right by one, shift alu_out into result MSB (result shifts right), load chain from alu_cout, and increment the counter.
REQ-020 Bits SHALL be processed LSB first; after WORD SHIFT edges result[i] SHALL equal the slice output for bit i.
REQ-021 After the WORD-th SHIFT edge the FSM SHALL enter DONE and set cout to the final chain value.
REQ-022 DONE SHALL last exactly one cycle with valid=1, then return to IDLE.
REQ-023 Latency SHALL be WORD cycles from accept edge to valid high, and WORD+2 edges from accept to the next accept opportunity.
REQ-024 Outside SHIFT, alu_a, alu_b, alu_c SHALL be 0 and alu_s SHALL be 3'b000.
REQ-025 result and cout SHALL hold their DONE values through IDLE until the next accepted start; during SHIFT they are undefined and SHALL not be relied on.
REQ-026 op SHALL be forwarded unmodified; the block SHALL not interpret op values.
REQ-027 The counter SHALL be ceil(log2(WORD+1)) bits wide and SHALL not wrap within an operation.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy=0, valid=0, result=0, cout=0, chain=0, counter=0, all alu_* outputs 0, independent of clk.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no valid pulse; the first start after release SHALL behave as from power-up.
REQ-030 start high on the edge on which rst_n deasserts SHALL be accepted only if rst_n is high at that edge with setup met; otherwise ignored.

Verification (WORD=4, real slice in loop, op=0: out=a!=b, cout=c&(a!=b))
REQ-031 opa=1010, opb=0101, cin=1, start -> valid after 4 cycles, result=1111, cout=1.
REQ-032 opa=0110, opb=0101, cin=1 -> result=0011, cout=0.
REQ-033 opa=opb=1001, cin=1 -> result=0000, cout=0; alu_c observed 1,0,0,0 over SHIFT.
REQ-034 start held high continuously -> accepts every 6 edges, valid single-cycle each time, operands changed during SHIFT have no effect.
REQ-035 rst_n low at SHIFT bit 2 -> all outputs 0 asynchronously, no valid; subsequent op from REQ-031 returns 1111/1.
REQ-036 Idle check: no start for 10 cycles -> busy=0, valid=0, alu_* all 0, result/cout unchanged.
